// File: rtl/div_ctrl_pkg.sv
// Shared encodings and types for the integer-divide sequencer.
// Opcodes follow EX decode; the result payload mirrors the divider's 64-bit output.
package div_ctrl_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned RD_W = 5;

   localparam logic [1:0] DIV_OP_DIV  = 2'b00;
   localparam logic [1:0] DIV_OP_DIVU = 2'b01;
   localparam logic [1:0] DIV_OP_REM  = 2'b10;
   localparam logic [1:0] DIV_OP_REMU = 2'b11;

   typedef enum logic [2:0] {
      DIVC_IDLE,
      DIVC_FAST,
      DIVC_BUSY,
      DIVC_DONE,
      DIVC_ABORT
   } divc_state_t;

   typedef struct packed {
      logic [XLEN-1:0] rem;
      logic [XLEN-1:0] quo;
   } div_result_t;

   function automatic logic op_is_signed(input logic [1:0] op);
      return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
   endfunction

   function automatic logic op_is_rem(input logic [1:0] op);
      return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
   endfunction

endpackage

// File: rtl/div_special.sv
// Detects divide-by-zero and signed overflow and forms the architectural result
// for them, so those cases never reach the iterative divider.
module div_special
   import div_ctrl_pkg::*;
(
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            is_special,
   output logic [XLEN-1:0] fast_result
);

   localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ALL_ONES = '1;

   logic div_zero;
   logic overflow;

   always_comb begin
      div_zero    = (rs2 == '0);
      overflow    = op_is_signed(op) && (rs1 == INT_MIN) && (rs2 == ALL_ONES);
      is_special  = div_zero || overflow;
      fast_result = '0;
      if (div_zero) begin
         fast_result = op_is_rem(op) ? rs1 : ALL_ONES;
      end else if (overflow) begin
         fast_result = op_is_rem(op) ? '0 : INT_MIN;
      end
   end

endmodule

// File: rtl/div_ctrl.sv
// EX-stage divide sequencer: resolves special cases locally, otherwise launches
// the iterative divider, stalls the pipe until it answers, and aborts on flush.
module div_ctrl
   import div_ctrl_pkg::*;
(
   input  logic              clk_i,
   input  logic              n_rst_i,
   input  logic              req_i,
   input  logic [1:0]        op_i,
   input  logic [XLEN-1:0]   rs1_i,
   input  logic [XLEN-1:0]   rs2_i,
   input  logic [RD_W-1:0]   rd_addr_i,
   input  logic              flush_i,
   output logic              stall_o,
   output logic              result_valid_o,
   output logic [XLEN-1:0]   result_o,
   output logic [RD_W-1:0]   rd_addr_o,
   output logic              div_start_o,
   output logic              div_signed_o,
   output logic              div_annul_o,
   output logic [XLEN-1:0]   div_dividend_o,
   output logic [XLEN-1:0]   div_divisor_o,
   input  logic              div_ready_i,
   input  logic [2*XLEN-1:0] div_result_i
);

   divc_state_t     state;
   logic            rem_q;
   logic            valid_q;
   logic [RD_W-1:0] rd_q;
   logic            launch;
   logic            is_special;
   logic [XLEN-1:0] fast_result;
   div_result_t     div_res;

   div_special u_special (
      .op          (op_i),
      .rs1         (rs1_i),
      .rs2         (rs2_i),
      .is_special  (is_special),
      .fast_result (fast_result)
   );

   assign div_res = div_result_t'(div_result_i);
   // Divider must have dropped ready from the previous op before a new start.
   assign launch  = (state == DIVC_IDLE) && req_i && !flush_i && !div_ready_i;

   assign stall_o = ((state == DIVC_IDLE) && req_i && !flush_i)
                  || (state == DIVC_BUSY) || (state == DIVC_ABORT);
   // A flush landing on the write-back cycle kills the strobe.
   assign result_valid_o = valid_q && !flush_i;

   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         state          <= DIVC_IDLE;
         rem_q          <= 1'b0;
         valid_q        <= 1'b0;
         rd_q           <= '0;
         result_o       <= '0;
         rd_addr_o      <= '0;
         div_start_o    <= 1'b0;
         div_signed_o   <= 1'b0;
         div_annul_o    <= 1'b0;
         div_dividend_o <= '0;
         div_divisor_o  <= '0;
      end else begin
         case (state)
            DIVC_IDLE: begin
               if (launch) begin
                  rem_q          <= op_is_rem(op_i);
                  rd_q           <= rd_addr_i;
                  div_dividend_o <= rs1_i;
                  div_divisor_o  <= rs2_i;
                  if (is_special) begin
                     result_o  <= fast_result;
                     rd_addr_o <= rd_addr_i;
                     valid_q   <= 1'b1;
                     state     <= DIVC_FAST;
                  end else begin
                     div_start_o  <= 1'b1;
                     div_signed_o <= op_is_signed(op_i);
                     state        <= DIVC_BUSY;
                  end
               end
            end
            DIVC_FAST, DIVC_DONE: begin
               valid_q <= 1'b0;
               state   <= DIVC_IDLE;
            end
            DIVC_BUSY: begin
               if (flush_i) begin
                  div_start_o <= 1'b0;
                  div_annul_o <= 1'b1;
                  state       <= DIVC_ABORT;
               end else if (div_ready_i) begin
                  result_o    <= rem_q ? div_res.rem : div_res.quo;
                  rd_addr_o   <= rd_q;
                  div_start_o <= 1'b0;
                  valid_q     <= 1'b1;
                  state       <= DIVC_DONE;
               end
            end
            DIVC_ABORT: begin
               div_annul_o <= 1'b0;
               state       <= DIVC_IDLE;
            end
            default: state <= DIVC_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl with a behavioural iterative-divider stand-in.
module tb_div_ctrl;

   localparam int unsigned LAT = 35;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        req = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] rs1 = '0;
   logic [31:0] rs2 = '0;
   logic [4:0]  rd = '0;
   logic        flush = 1'b0;
   logic        stall_o, result_valid_o, div_start_o, div_signed_o, div_annul_o;
   logic [31:0] result_o, div_dividend_o, div_divisor_o;
   logic [4:0]  rd_addr_o;
   logic        mready;
   logic [63:0] mres;
   logic [5:0]  cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      string       name;
   } exp_t;
   exp_t exp_q[$];

   div_ctrl dut (
      .clk_i          (clk),
      .n_rst_i        (n_rst),
      .req_i          (req),
      .op_i           (op),
      .rs1_i          (rs1),
      .rs2_i          (rs2),
      .rd_addr_i      (rd),
      .flush_i        (flush),
      .stall_o        (stall_o),
      .result_valid_o (result_valid_o),
      .result_o       (result_o),
      .rd_addr_o      (rd_addr_o),
      .div_start_o    (div_start_o),
      .div_signed_o   (div_signed_o),
      .div_annul_o    (div_annul_o),
      .div_dividend_o (div_dividend_o),
      .div_divisor_o  (div_divisor_o),
      .div_ready_i    (mready),
      .div_result_i   (mres)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] div_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic sgn);
      logic [31:0] q, r;
      if (b == 0) begin
         q = '1;
         r = a;
      end else if (sgn) begin
         q = 32'($signed(a) / $signed(b));
         r = 32'($signed(a) % $signed(b));
      end else begin
         q = a / b;
         r = a % b;
      end
      return {r, q};
   endfunction

   // Divider stand-in: ready after LAT counted start cycles, held until start drops.
   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         mready <= 1'b0;
         cnt    <= '0;
         mres   <= '0;
      end else if (div_annul_o || !div_start_o) begin
         mready <= 1'b0;
         cnt    <= '0;
      end else if (!mready) begin
         if (cnt == 6'(LAT - 1)) begin
            mready <= 1'b1;
            mres   <= div_model(div_dividend_o, div_divisor_o, div_signed_o);
         end else begin
            cnt <= cnt + 6'd1;
         end
      end
   end

   // Monitor: every write-back strobe must match the oldest expected result.
   always @(negedge clk) begin
      if (n_rst && result_valid_o) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_writeback: result=%h rd=%0d, required no strobe",
                     result_o, rd_addr_o);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (result_o !== e.res || rd_addr_o !== e.rd) begin
               errors++;
               $display("FAIL %s: result=%h rd=%0d, required result=%h rd=%0d",
                        e.name, result_o, rd_addr_o, e.res, e.rd);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] d,
                        input logic [31:0] exp_res, input bit fast);
      int  stalls = 0;
      int  starts = 0;
      bit  done = 0;
      @(negedge clk);
      req = 1'b1; op = o; rs1 = a; rs2 = b; rd = d;
      exp_q.push_back('{exp_res, d, name});
      #1;
      for (int i = 0; i < 200 && !done; i++) begin
         if (div_start_o) starts++;
         if (stall_o) begin
            stalls++;
            @(negedge clk);
            #1;
         end else begin
            done = 1;
         end
      end
      req = 1'b0;
      chk({name, "_completed"}, 64'(done), 64'd1);
      chk({name, "_stall_cycles"}, 64'(stalls), fast ? 64'd1 : 64'(LAT + 2));
      chk({name, "_start_cycles"}, 64'(starts), fast ? 64'd0 : 64'(LAT + 1));
      chk({name, "_writeback_seen"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      @(negedge clk);
   endtask

   initial begin
      int annuls;
      repeat (3) @(negedge clk);
      chk("reset_ctrl", {stall_o, result_valid_o, div_start_o, div_signed_o, div_annul_o,
                         rd_addr_o}, 64'd0);
      chk("reset_data", {result_o, div_dividend_o}, 64'd0);
      n_rst = 1'b1;
      @(negedge clk);

      do_op("divu_100_7",   2'b01, 32'd100,        32'd7,          5'd1,  32'd14,         0);
      do_op("remu_100_7",   2'b11, 32'd100,        32'd7,          5'd2,  32'd2,          0);
      do_op("div_m20_3",    2'b00, 32'hFFFFFFEC,   32'd3,          5'd3,  32'hFFFFFFFA,   0);
      do_op("rem_m20_3",    2'b10, 32'hFFFFFFEC,   32'd3,          5'd4,  32'hFFFFFFFE,   0);
      do_op("divu_by_zero", 2'b01, 32'h1234,       32'd0,          5'd5,  32'hFFFFFFFF,   1);
      do_op("remu_by_zero", 2'b11, 32'h1234,       32'd0,          5'd6,  32'h1234,       1);
      do_op("div_ovf",      2'b00, 32'h80000000,   32'hFFFFFFFF,   5'd7,  32'h80000000,   1);
      do_op("rem_ovf",      2'b10, 32'h80000000,   32'hFFFFFFFF,   5'd8,  32'd0,          1);
      do_op("divu_ovf_ops", 2'b01, 32'h80000000,   32'hFFFFFFFF,   5'd9,  32'd0,          0);

      // Flush ten cycles into BUSY.
      @(negedge clk);
      req = 1'b1; op = 2'b01; rs1 = 32'd1000; rs2 = 32'd7; rd = 5'd10;
      repeat (10) @(negedge clk);
      #1;
      chk("flush_busy_start", 64'(div_start_o), 64'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0; req = 1'b0;
      #1;
      chk("abort_annul", 64'(div_annul_o), 64'd1);
      chk("abort_start", 64'(div_start_o), 64'd0);
      chk("abort_stall", 64'(stall_o), 64'd1);
      annuls = 0;
      repeat (4) begin
         @(negedge clk);
         #1;
         if (div_annul_o) annuls++;
      end
      chk("annul_single_cycle", 64'(annuls), 64'd0);
      do_op("divu_9_3_after_flush", 2'b01, 32'd9, 32'd3, 5'd17, 32'd3, 0);

      // Asynchronous reset in the middle of a divide.
      @(negedge clk);
      req = 1'b1; op = 2'b11; rs1 = 32'd1000; rs2 = 32'd3; rd = 5'd20;
      repeat (5) @(negedge clk);
      #2;
      n_rst = 1'b0; req = 1'b0;
      #1;
      chk("midrst_ctrl", {stall_o, result_valid_o, div_start_o, div_signed_o, div_annul_o,
                          rd_addr_o}, 64'd0);
      chk("midrst_result", {result_o, div_dividend_o}, 64'd0);
      chk("midrst_divisor", 64'(div_divisor_o), 64'd0);
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
      do_op("remu_17_5_after_rst", 2'b11, 32'd17, 32'd5, 5'd21, 32'd2, 0);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
